// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: FSM state encoding and bus width/byte-enable constants
// shared by mem_bus_arbiter and its watchdog.
package mem_bus_arbiter_pkg;
  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_DATA = 2'd1;
  localparam logic [1:0] ARB_INST = 2'd2;
  localparam logic [3:0] BE_FULL = 4'hF;
endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// bus_watchdog: counts stalled bus cycles and flags a timeout; o_err is the
// registered one-cycle error pulse that lines up with the forced ack.
module bus_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_busy,
  input  logic i_ready,
  output logic o_timeout,
  output logic o_err
);
  logic [15:0] r_cnt;
  // fires on the stalled cycle whose increment would reach TIMEOUT_CYCLES
  assign o_timeout = i_busy & ~i_ready & (r_cnt == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      o_err <= 1'b0;
    end else begin
      o_err <= o_timeout;
      r_cnt <= i_start ? '0 : (i_busy & ~i_ready) ? r_cnt + 16'd1 : r_cnt;
    end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: IF/MEM single-port bus arbiter, data priority, pipeline pause.
// Define BUS_TIMEOUT_EN to build in the bus watchdog (bus_err_o otherwise tied 0).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [BUS_AW-1:0] if_addr_i,
  input  logic              if_abort_i,
  output logic [BUS_DW-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_be_i,
  input  logic [BUS_AW-1:0] mem_addr_i,
  input  logic [BUS_DW-1:0] mem_wdata_i,
  output logic [BUS_DW-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_be_o,
  output logic [BUS_AW-1:0] bus_addr_o,
  output logic [BUS_DW-1:0] bus_wdata_o,
  input  logic [BUS_DW-1:0] bus_rdata_i,
  input  logic              bus_ready_i,
  output logic              bus_err_o,
  output logic              pause_o
);
  logic [1:0]        r_state;
  logic              r_abort, r_if_ack, r_mem_ack, r_bus_req, r_bus_we;
  logic [3:0]        r_bus_be;
  logic [BUS_AW-1:0] r_bus_addr;
  logic [BUS_DW-1:0] r_bus_wdata, r_if_rdata, r_mem_rdata, w_rdata;
  logic              w_idle, w_mem_go, w_if_go, w_done, w_timeout;
  assign w_idle = r_state == ARB_IDLE;
  // the port acked this cycle is masked so a still-high req is not reissued
  assign w_mem_go = w_idle & mem_req_i & ~r_mem_ack;
  assign w_if_go = w_idle & ~w_mem_go & if_req_i & ~if_abort_i & ~r_if_ack;
  assign w_done = ~w_idle & (bus_ready_i | w_timeout);
  assign w_rdata = w_timeout ? '0 : bus_rdata_i;
`ifdef BUS_TIMEOUT_EN
  bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk(clk), .rst_n(rst_n), .i_start(w_mem_go | w_if_go), .i_busy(~w_idle),
    .i_ready(bus_ready_i), .o_timeout(w_timeout), .o_err(bus_err_o)
  );
`else
  // constant 0 for any legal TIMEOUT_CYCLES; the bus simply waits forever
  assign w_timeout = TIMEOUT_CYCLES == 0;
  assign bus_err_o = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_abort <= 1'b0;
      r_if_ack <= 1'b0;
      r_mem_ack <= 1'b0;
      r_bus_req <= 1'b0;
      r_bus_we <= 1'b0;
      r_bus_be <= '0;
      r_bus_addr <= '0;
      r_bus_wdata <= '0;
      r_if_rdata <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_mem_ack <= 1'b0;
      if (w_mem_go | w_if_go) begin
        r_state <= w_mem_go ? ARB_DATA : ARB_INST;
        r_bus_req <= 1'b1;
        r_bus_we <= w_mem_go & mem_we_i;
        r_bus_be <= w_mem_go ? mem_be_i : BE_FULL;
        r_bus_addr <= w_mem_go ? mem_addr_i : if_addr_i;
        r_bus_wdata <= w_mem_go ? mem_wdata_i : '0;
      end else if (w_done) begin
        r_state <= ARB_IDLE;
        r_bus_req <= 1'b0;
        r_abort <= 1'b0;
        if (r_state == ARB_DATA) begin
          r_mem_ack <= 1'b1;
          if (!r_bus_we) r_mem_rdata <= w_rdata;
        end else if (!(r_abort | if_abort_i)) begin
          r_if_ack <= 1'b1;
          r_if_rdata <= w_rdata;
        end
      end else if (r_state == ARB_INST && if_abort_i) begin
        r_abort <= 1'b1;
      end
    end
  end
  assign if_ack_o = r_if_ack;
  assign mem_ack_o = r_mem_ack;
  assign if_rdata_o = r_if_rdata;
  assign mem_rdata_o = r_mem_rdata;
  assign bus_req_o = r_bus_req;
  assign bus_we_o = r_bus_we;
  assign bus_be_o = r_bus_be;
  assign bus_addr_o = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;
  assign pause_o = (mem_req_i & ~r_mem_ack) | (if_req_i & ~r_if_ack & ~if_abort_i);
endmodule
